// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Instruction fetch front end. It keeps at most one memory request in
// flight, sequences the fetch PC and buffers fetched words with their PCs in a
// small FIFO for the decode stage. A redirect flushes the buffer and retargets
// the fetch PC. If a response is still outstanding at that point, it is dropped
// when it arrives.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   imem_req        fetch request valid (combinational)
//   imem_addr       fetch address (combinational, equals fetch PC)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid
//   imem_rdata      response instruction word
//   inst_valid      head entry available to the consumer
//   inst            instruction word at the buffer head
//   inst_pc         PC of the head instruction
//   inst_ready      consumer accepts the head entry
//   redirect_valid  branch/jump redirect this cycle
//   redirect_pc     redirect target (low two bits ignored)
//   fifo_count      number of occupied buffer entries
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_ready,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [XLEN-1:0]            inst_pc,
  input  logic                       inst_ready,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic [CW-1:0]   count_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [31:0]     buf_inst_r [DEPTH];
  logic [XLEN-1:0] buf_pc_r   [DEPTH];

  logic            issue_s;
  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  logic            head_valid_s;
  logic [XLEN-1:0] redirect_aligned_s;

  // Masking instead of slicing keeps every redirect_pc bit in use.
  assign redirect_aligned_s = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. A response always ends WAIT/DROP, because it settles the
  // single outstanding request even when it is discarded.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_next_s = ST_RUN;
        end else if (redirect_valid) begin
          state_next_s = ST_DROP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_DROP;
        end
      end
      default: begin
        state_next_s = ST_RUN;
      end
    endcase
  end

  // Output and handshake decode. Requests are issued only from RUN with a free
  // slot, so a response can never meet a full buffer.
  always_comb begin
    issue_s      = 1'b0;
    push_s       = 1'b0;
    head_valid_s = 1'b0;
    if (rst && (state_r == ST_RUN) && (count_r < CW'(DEPTH)) && !redirect_valid) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if ((state_r == ST_WAIT) && imem_rvalid && !redirect_valid) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if ((count_r != {CW{1'b0}}) && !redirect_valid) begin
      head_valid_s = 1'b1;
    end else begin
      head_valid_s = 1'b0;
    end
  end

  assign accept_s   = issue_s && imem_ready;
  assign pop_s      = head_valid_s && inst_ready;
  assign imem_req   = issue_s;
  assign imem_addr  = fetch_pc_r;
  assign inst_valid = head_valid_s;
  assign inst       = buf_inst_r[rd_ptr_r];
  assign inst_pc    = buf_pc_r[rd_ptr_r];
  assign fifo_count = count_r;

  // Fetch PC: redirect has priority; otherwise advance after each kept response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_aligned_s;
    end else if (push_s) begin
      fetch_pc_r <= fetch_pc_r + XLEN'(3'd4);
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // Occupancy and pointers; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
    end else if (redirect_valid) begin
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Buffer storage, written at the tail on each kept response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst_r[i] <= 32'h0000_0000;
        buf_pc_r[i]   <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      buf_inst_r[wr_ptr_r] <= imem_rdata;
      buf_pc_r[wr_ptr_r]   <= fetch_pc_r;
    end else begin
      buf_inst_r[wr_ptr_r] <= buf_inst_r[wr_ptr_r];
      buf_pc_r[wr_ptr_r]   <= buf_pc_r[wr_ptr_r];
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [2:0]  fifo_count;

  int n_applied = 0;
  int n_fail    = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        ir;
    logic        rdv;
    logic [31:0] rdpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    int          e_cnt;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  inst_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] dat(input logic [31:0] pc);
    return 32'hA000_0000 ^ pc;
  endfunction

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rdata,
                     input logic ir, input logic rdv, input logic [31:0] rdpc,
                     input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_inst, input logic [31:0] e_ipc, input int e_cnt);
    vecs[nvec] = '{rdy, rv, rdata, ir, rdv, rdpc, e_req, e_addr, e_iv, e_inst, e_ipc, e_cnt};
    nvec++;
  endtask

  task automatic check(input string nm, input logic e_req, input logic [31:0] e_addr,
                       input logic e_iv, input logic [31:0] e_inst,
                       input logic [31:0] e_ipc, input int e_cnt);
    bit bad = 1'b0;
    n_applied++;
    if (imem_req !== e_req) begin
      $display("FAIL %s imem_req: got %b want %b", nm, imem_req, e_req); bad = 1'b1;
    end
    if (imem_addr !== e_addr) begin
      $display("FAIL %s imem_addr: got %h want %h", nm, imem_addr, e_addr); bad = 1'b1;
    end
    if (inst_valid !== e_iv) begin
      $display("FAIL %s inst_valid: got %b want %b", nm, inst_valid, e_iv); bad = 1'b1;
    end
    if (int'(fifo_count) != e_cnt) begin
      $display("FAIL %s fifo_count: got %0d want %0d", nm, fifo_count, e_cnt); bad = 1'b1;
    end
    if (e_iv && (inst !== e_inst)) begin
      $display("FAIL %s inst: got %h want %h", nm, inst, e_inst); bad = 1'b1;
    end
    if (e_iv && (inst_pc !== e_ipc)) begin
      $display("FAIL %s inst_pc: got %h want %h", nm, inst_pc, e_ipc); bad = 1'b1;
    end
    if (bad) n_fail++;
  endtask

  task automatic apply(input int i);
    @(negedge clk);
    imem_ready     = vecs[i].rdy;
    imem_rvalid    = vecs[i].rv;
    imem_rdata     = vecs[i].rdata;
    inst_ready     = vecs[i].ir;
    redirect_valid = vecs[i].rdv;
    redirect_pc    = vecs[i].rdpc;
    #1;
    check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
          vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_cnt);
  endtask

  initial begin
    // Sequential fetch with a consumer that always accepts.
    add(1,0,32'h0,1,0,32'h0,         1,32'h0,0,32'h0,32'h0,0);
    add(0,1,dat(32'h0),1,0,32'h0,    0,32'h0,0,32'h0,32'h0,0);
    add(1,0,32'h0,1,0,32'h0,         1,32'h4,1,dat(32'h0),32'h0,1);
    add(0,1,dat(32'h4),1,0,32'h0,    0,32'h4,0,32'h0,32'h0,0);
    add(1,0,32'h0,1,0,32'h0,         1,32'h8,1,dat(32'h4),32'h4,1);
    add(0,1,dat(32'h8),1,0,32'h0,    0,32'h8,0,32'h0,32'h0,0);
    add(1,0,32'h0,1,0,32'h0,         1,32'hC,1,dat(32'h8),32'h8,1);
    add(0,1,dat(32'hC),1,0,32'h0,    0,32'hC,0,32'h0,32'h0,0);
    // Stalled consumer: fill to DEPTH, request stops, one pop restarts it.
    add(1,0,32'h0,0,0,32'h0,         1,32'h10,1,dat(32'hC),32'hC,1);
    add(0,1,dat(32'h10),0,0,32'h0,   0,32'h10,1,dat(32'hC),32'hC,1);
    add(1,0,32'h0,0,0,32'h0,         1,32'h14,1,dat(32'hC),32'hC,2);
    add(0,1,dat(32'h14),0,0,32'h0,   0,32'h14,1,dat(32'hC),32'hC,2);
    add(1,0,32'h0,0,0,32'h0,         1,32'h18,1,dat(32'hC),32'hC,3);
    add(0,1,dat(32'h18),0,0,32'h0,   0,32'h18,1,dat(32'hC),32'hC,3);
    add(1,0,32'h0,0,0,32'h0,         0,32'h1C,1,dat(32'hC),32'hC,4);
    add(0,0,32'h0,1,0,32'h0,         0,32'h1C,1,dat(32'hC),32'hC,4);
    add(1,0,32'h0,0,0,32'h0,         1,32'h1C,1,dat(32'h10),32'h10,3);
    // Redirect to 0x103 while waiting; the late response is dropped.
    add(1,0,32'h0,0,1,32'h103,       0,32'h1C,0,32'h0,32'h0,3);
    add(0,0,32'h0,0,0,32'h0,         0,32'h100,0,32'h0,32'h0,0);
    add(0,0,32'h0,0,0,32'h0,         0,32'h100,0,32'h0,32'h0,0);
    add(0,1,32'hDEAD_BEEF,0,0,32'h0, 0,32'h100,0,32'h0,32'h0,0);
    add(1,0,32'h0,1,0,32'h0,         1,32'h100,0,32'h0,32'h0,0);
    add(0,1,dat(32'h100),1,0,32'h0,  0,32'h100,0,32'h0,32'h0,0);
    // Redirect together with rvalid and inst_ready: no push, no pop.
    add(1,0,32'h0,0,0,32'h0,         1,32'h104,1,dat(32'h100),32'h100,1);
    add(0,1,dat(32'h104),1,1,32'h40, 0,32'h104,0,32'h0,32'h0,1);
    add(0,0,32'h0,1,0,32'h0,         1,32'h40,0,32'h0,32'h0,0);
    // Two redirects while dropping: the latest target wins.
    add(1,0,32'h0,1,0,32'h0,         1,32'h40,0,32'h0,32'h0,0);
    add(0,0,32'h0,1,1,32'h200,       0,32'h40,0,32'h0,32'h0,0);
    add(0,0,32'h0,1,1,32'h300,       0,32'h200,0,32'h0,32'h0,0);
    add(0,1,32'hDEAD_BEEF,1,0,32'h0, 0,32'h300,0,32'h0,32'h0,0);
    add(1,0,32'h0,1,0,32'h0,         1,32'h300,0,32'h0,32'h0,0);
    add(0,1,dat(32'h300),1,0,32'h0,  0,32'h300,0,32'h0,32'h0,0);
    add(0,0,32'h0,1,0,32'h0,         1,32'h304,1,dat(32'h300),32'h300,1);
    // Address wrap from 0xFFFFFFFC to 0x0.
    add(0,0,32'h0,1,1,32'hFFFF_FFFE, 0,32'h304,0,32'h0,32'h0,0);
    add(1,0,32'h0,1,0,32'h0,         1,32'hFFFF_FFFC,0,32'h0,32'h0,0);
    add(0,1,dat(32'hFFFF_FFFC),1,0,32'h0, 0,32'hFFFF_FFFC,0,32'h0,32'h0,0);
    add(1,0,32'h0,0,0,32'h0,         1,32'h0,1,dat(32'hFFFF_FFFC),32'hFFFF_FFFC,1);
    add(0,1,dat(32'h0),0,0,32'h0,    0,32'h0,1,dat(32'hFFFF_FFFC),32'hFFFF_FFFC,1);
    add(0,0,32'h0,1,0,32'h0,         1,32'h4,1,dat(32'hFFFF_FFFC),32'hFFFF_FFFC,2);
    add(0,0,32'h0,1,0,32'h0,         1,32'h4,1,dat(32'h0),32'h0,1);
    add(0,0,32'h0,1,0,32'h0,         1,32'h4,0,32'h0,32'h0,0);
    // Fill three entries, then sit in WAIT with every slot committed.
    add(1,0,32'h0,0,0,32'h0,         1,32'h4,0,32'h0,32'h0,0);
    add(0,1,dat(32'h4),0,0,32'h0,    0,32'h4,0,32'h0,32'h0,0);
    add(1,0,32'h0,0,0,32'h0,         1,32'h8,1,dat(32'h4),32'h4,1);
    add(0,1,dat(32'h8),0,0,32'h0,    0,32'h8,1,dat(32'h4),32'h4,1);
    add(1,0,32'h0,0,0,32'h0,         1,32'hC,1,dat(32'h4),32'h4,2);
    add(0,1,dat(32'hC),0,0,32'h0,    0,32'hC,1,dat(32'h4),32'h4,2);
    add(1,0,32'h0,0,0,32'h0,         1,32'h10,1,dat(32'h4),32'h4,3);
    add(0,0,32'h0,0,0,32'h0,         0,32'h10,1,dat(32'h4),32'h4,3);

    #12;
    check("reset_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_release", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 0);

    for (int i = 0; i < nvec; i++) apply(i);

    // Asynchronous reset in the middle of a WAIT cycle, before any clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("reset_async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 0);
    @(negedge clk);
    #1;
    check("reset_async_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 0);
    rst = 1'b1;
    #1;
    check("reset_rerelease", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 0);
    @(negedge clk);
    imem_ready = 1'b1;
    #1;
    check("post_reset_issue", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 0);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    check("post_reset_wait", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC and address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries; legal values are powers of 2 and at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the first fetch address; its two LSBs are zero.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have these ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction word.
- inst_valid  out  1  buffered instruction available.
- inst  out  32  instruction at the buffer head.
- inst_pc  out  XLEN  PC of `inst`.
- inst_ready  in  1  consumer accepts the head entry.
- redirect_valid  in  1  branch or jump redirect.
- redirect_pc  in  XLEN  redirect target.
- fifo_count  out  clog2(DEPTH)+1  number of occupied buffer entries.

Function
REQ-006 SHALL implement a three-state FSM, RUN / WAIT / DROP, with at most one outstanding memory request.
REQ-007 SHALL drive imem_req = (state==RUN) && (fifo_count<DEPTH) && !redirect_valid, with imem_addr = fetch_pc; both are combinational.
REQ-008 SHALL hold imem_req and imem_addr stable until imem_ready, unless a redirect occurs.
REQ-009 SHALL, on imem_req && imem_ready, transition RUN->WAIT and reserve one buffer slot.
REQ-010 SHALL, in WAIT, on imem_rvalid without redirect, push {imem_rdata, fetch_pc}, set fetch_pc += 4 (modulo 2^XLEN), and return to RUN. The next request may assert in the following cycle.
REQ-011 SHALL treat imem_rvalid in RUN as a protocol error and ignore it.
REQ-012 SHALL, on redirect_valid, flush all buffer entries and load fetch_pc with {redirect_pc[XLEN-1:2], 2'b00} at the same edge.
REQ-013 SHALL apply these redirect transitions:
- In RUN: stay in RUN.
- In WAIT with no rvalid in the same cycle: go to DROP.
- In WAIT with rvalid in the same cycle: discard the response and go to RUN.
- In DROP: stay in DROP and take the latest redirect_pc.
REQ-014 SHALL, in DROP, discard the rvalid response (no push, fetch_pc unchanged) and go to RUN.
REQ-015 SHALL drive inst_valid = (fifo_count!=0) && !redirect_valid; a pop occurs only when inst_valid && inst_ready.
REQ-016 SHALL present inst and inst_pc from the head entry; they are stable while inst_valid && !inst_ready.
REQ-017 SHALL, on a simultaneous push and pop, leave fifo_count unchanged and preserve order.
REQ-018 SHALL have no empty-buffer bypass: rvalid in cycle N gives inst_valid no earlier than cycle N+1.
REQ-019 SHALL guarantee a push never finds the buffer full, because the slot was reserved at issue.
REQ-020 SHALL let the buffer read and write pointers wrap modulo DEPTH.

Reset
REQ-021 SHALL, while rst==0 (asynchronous), hold state=RUN, fetch_pc=RESET_PC, fifo_count=0, inst_valid=0, imem_req=0, and pointers at 0.
REQ-022 SHALL, in the first cycle after rst rises, assert imem_req with imem_addr=RESET_PC.
REQ-023 SHALL, on reset mid-request, abandon any outstanding response; the bench does not return rvalid after reset.

Verification
REQ-024 SHALL cover these directed scenarios:
- Reset release, imem_ready=1, rvalid one cycle after each accept, inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8, 0xC; inst_valid first high 2 cycles after the first accept.
- inst_ready=0 with DEPTH=4 -> fifo_count reaches 4, then imem_req stays 0; one pop -> imem_req reasserts next cycle with the next sequential address.
- Redirect to 0x103 while in WAIT, rvalid 3 cycles later -> response discarded, fifo_count=0, next imem_addr=0x100.
- Redirect in the same cycle as rvalid and an inst_ready pop -> no push, no pop observed, fifo_count=0 next cycle, FSM in RUN.
- Two redirects in consecutive DROP cycles (0x200 then 0x300) -> the first fetch after the drop targets 0x300.
- fetch_pc=2^XLEN-4 -> next sequential fetch targets 0x0 (wrap).
- rst asserted mid-WAIT with a full buffer -> all outputs at reset values immediately, without waiting for a clock edge.
